// File: rtl/riscv_pkg.sv
// Shared pipeline types and constants for the RV32 core control blocks.
package riscv_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the ID sources and the load in EX; purely combinational.
// No backpressure; x0 destinations never match.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard    = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipe; outputs combinational (0 cycles) from inputs and state.
// Priority: dmem_busywait > flush > load-use > imem_busywait; a branch seen during a dmem stall is held until the stall ends.
module pipeline_hazard_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        dmem_busywait,
    input  logic        imem_busywait,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        mem_wb_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
);

    hazard_state_t state_q;
    hazard_state_t state_d;
    logic          pending_flush_q;
    logic          pending_flush_d;
    logic          load_use;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (load_use)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= RUN;
            pending_flush_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pending_flush_d = 1'b0;
        pc_stall        = 1'b0;
        if_id_stall     = 1'b0;
        id_ex_stall     = 1'b0;
        ex_mem_stall    = 1'b0;
        mem_wb_stall    = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;

        if (state_q == RUN && dmem_busywait) begin
            state_d = MEM_WAIT;
        end else if (state_q == MEM_WAIT && !dmem_busywait) begin
            state_d = RUN;
        end

        // Bubbles are forced into the pipe registers for as long as reset is held.
        if (reset) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (dmem_busywait) begin
            pc_stall        = 1'b1;
            if_id_stall     = 1'b1;
            id_ex_stall     = 1'b1;
            ex_mem_stall    = 1'b1;
            mem_wb_stall    = 1'b1;
            pending_flush_d = pending_flush_q || ex_branch_taken;
        end else if (ex_branch_taken || pending_flush_q) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (imem_busywait) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_events <= 16'd0;
        end else begin
            if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (if_id_flush && id_ex_flush) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vectors drive the controller one cycle each; a monitor pops expected responses and compares them.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        dmem_busywait;
    logic        imem_busywait;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        ex_mem_stall;
    logic        mem_wb_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [31:0] sc;
        logic [15:0] fe;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busywait   (dmem_busywait),
        .imem_busywait   (imem_busywait),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .ex_mem_stall    (ex_mem_stall),
        .mem_wb_stall    (mem_wb_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {pc, if_id_s, id_ex_s, ex_mem_s, mem_wb_s, if_id_f, id_ex_f}; sc/fe are counter values during the cycle.
    task automatic vec(input string nm, input logic rst,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic dm, input logic im,
                       input logic [6:0] ctrl, input logic [31:0] sc, input logic [15:0] fe);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        id_rs1          = rs1;
        id_uses_rs1     = u1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
        ex_rd           = rd;
        ex_mem_read     = mr;
        ex_branch_taken = br;
        dmem_busywait   = dm;
        imem_busywait   = im;
        e.ctrl = ctrl;
        e.sc   = sc;
        e.fe   = fe;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t       e;
        string      nm;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall, if_id_flush, id_ex_flush};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL %s ctrl: got %b expected %b", nm, act, e.ctrl);
                end
                checks++;
                if (stall_cycles !== e.sc) begin
                    errors++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_cycles, e.sc);
                end
                checks++;
                if (flush_events !== e.fe) begin
                    errors++;
                    $display("FAIL %s flush_events: got %0d expected %0d", nm, flush_events, e.fe);
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        reset = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        dmem_busywait = 1'b0; imem_busywait = 1'b0;
        checks = 0;
        errors = 0;

        //   name            rst rs1 u1 rs2 u2  rd  mr br dm im  ctrl        sc  fe
        vec("reset_hold",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000011, 0, 0);
        vec("idle0",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0);
        vec("lu_rs1",        0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 7'b1100001, 0, 0);
        vec("idle1",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 1, 0);
        vec("lu_rd_x0",      0, 5, 1, 0, 0, 0, 1, 0, 0, 0, 7'b0000000, 1, 0);
        vec("lu_rs_rd_x0",   0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 7'b0000000, 1, 0);
        vec("lu_rs2",        0, 0, 0, 7, 1, 7, 1, 0, 0, 0, 7'b1100001, 1, 0);
        vec("rs2_unused",    0, 0, 0, 7, 0, 7, 1, 0, 0, 0, 7'b0000000, 2, 0);
        vec("dmem_c1",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111100, 2, 0);
        vec("dmem_c2_br",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b1111100, 3, 0);
        vec("dmem_c3",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111100, 4, 0);
        vec("pending_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000011, 5, 0);
        vec("after_flush",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 5, 1);
        vec("br_over_lu",    0, 5, 1, 0, 0, 5, 1, 1, 0, 0, 7'b0000011, 5, 1);
        vec("idle2",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 5, 2);
        vec("imem_c1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1000010, 5, 2);
        vec("imem_c2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1000010, 6, 2);
        vec("dmem_over_all", 0, 5, 1, 0, 0, 5, 1, 0, 1, 1, 7'b1111100, 7, 2);
        vec("mw_exit_lu",    0, 5, 1, 0, 0, 5, 1, 0, 0, 1, 7'b1100001, 8, 2);
        vec("idle3",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 9, 2);
        vec("dmem_br_pend",  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b1111100, 9, 2);
        vec("reset_mid_mw",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000011, 0, 0);
        vec("post_reset",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0);
        vec("post_reset2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-004 SHALL have ports id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads rs1/rs2.
REQ-005 SHALL have ports ex_rd  in  5, ex_mem_read  in  1  destination register and load flag of the instruction in EX (from the ID/EX register outputs).
REQ-006 SHALL have port ex_branch_taken  in  1  single-cycle pulse: branch/jump resolved taken in EX.
REQ-007 SHALL have ports dmem_busywait, imem_busywait  in  1 each  data/instruction memory not ready.
REQ-008 SHALL have ports pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1 each  hold the PC or that pipe register (id_ex_stall drives the ID/EX busywait input).
REQ-009 SHALL have ports if_id_flush, id_ex_flush  out  1 each  load a bubble (all-zero) into that pipe register.
REQ-010 SHALL have ports stall_cycles  out  32, flush_events  out  16  performance counters.

Function
REQ-011 SHALL hold a 2-state FSM: RUN, MEM_WAIT; plus a 1-bit pending_flush register.
REQ-012 Load-use hazard SHALL be ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-013 Priority within a cycle SHALL be: dmem_busywait > flush > load-use > imem_busywait.
REQ-014 While dmem_busywait=1 (either state) all five stall outputs SHALL be 1 and both flushes 0, combinationally in the same cycle; next state MEM_WAIT.
REQ-015 ex_branch_taken=1 while dmem_busywait=1 SHALL set pending_flush; no flush issued that cycle.
REQ-016 Flush condition SHALL be dmem_busywait=0 & (ex_branch_taken | pending_flush); response: if_id_flush=1, id_ex_flush=1, all stalls 0, for exactly one cycle; pending_flush cleared at the following edge.
REQ-017 Load-use (no higher-priority event) SHALL give pc_stall=1, if_id_stall=1, id_ex_flush=1, other outputs 0, for exactly the cycle the hazard is present (one bubble).
REQ-018 imem_busywait alone SHALL give pc_stall=1, if_id_flush=1, other outputs 0.
REQ-019 No event SHALL give all stall and flush outputs 0.
REQ-020 MEM_WAIT SHALL return to RUN on the first cycle dmem_busywait=0; that cycle is evaluated with normal RUN priority (flush, load-use, imem).
REQ-021 Register x0 SHALL never trigger a load-use hazard.
REQ-022 stall_cycles SHALL increment every cycle pc_stall=1, saturating at 0xFFFF_FFFF.
REQ-023 flush_events SHALL increment once per cycle with if_id_flush & id_ex_flush both 1, wrapping modulo 2^16.
REQ-024 Latency: all control outputs SHALL be combinational from current inputs and state (zero cycles); only state, pending_flush and counters are registered.

Reset
REQ-025 reset SHALL asynchronously force state=RUN, pending_flush=0, stall_cycles=0, flush_events=0.
REQ-026 While reset=1 all stall outputs SHALL be 0 and both flush outputs 1, so downstream pipe registers hold bubbles.
REQ-027 Reset asserted during MEM_WAIT with pending_flush=1 SHALL discard the pending flush; first cycle after release is evaluated in RUN.

Structure
REQ-028 The FSM enum hazard_state_t and constant REG_ZERO (5'd0) SHALL reside in the shared riscv_pkg.
REQ-029 Load-use comparison SHALL be a combinational sub-module load_use_detect (inputs REQ-003..005, output hazard).

Verification
REQ-030 id_rs1=5, id_uses_rs1=1, ex_rd=5, ex_mem_read=1 for one cycle -> pc_stall=1, if_id_stall=1, id_ex_flush=1 that cycle; stall_cycles +1.
REQ-031 Same as REQ-030 with ex_rd=0 -> all outputs 0.
REQ-032 dmem_busywait=1 for 3 cycles with ex_branch_taken pulsed in cycle 2 -> all stalls 1 for 3 cycles, no flush; cycle 4 (busywait=0) if_id_flush=id_ex_flush=1; flush_events=1; stall_cycles=3.
REQ-033 ex_branch_taken=1 and load-use hazard same cycle -> flushes only, pc_stall=0.
REQ-034 imem_busywait=1 for 2 cycles -> pc_stall=1, if_id_flush=1 both cycles; id_ex_stall=0.
REQ-035 reset asserted mid-MEM_WAIT with pending_flush=1, released, dmem_busywait=0 -> no flush issued; counters 0.
